mem_bank_seq: RTL and testbench
===============================

Name: mem_bank_seq

Overview:
Parametrised, clocked successor to the 4x8 byte memory system. It holds DEPTH words of WIDTH bits, written from switch data on a rising edge of the store strobe at the address on addr. The display path is registered and selects the word at addr, or auto-scans all entries when scan mode is on. A sequenced clear sweeps the bank one entry per cycle. It sits between the board switches/buttons and the LED display.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, number of entries (>=2; need not be a power of two)
ADDR_W, $clog2(DEPTH), address width
SCAN_DIV, 4, clock cycles each entry is displayed in scan mode (>=1)

Ports:
clk  input  1  single system clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk
data  input  WIDTH  write data
store  input  1  write strobe; level input, rising-edge detected internally
addr  input  ADDR_W  write address; also the display address when scan_en=0
clear  input  1  start clear sweep (level; acted on only when idle)
scan_en  input  1  1 = display address auto-cycles through all entries
memory  output  WIDTH  registered display word
disp_addr  output  ADDR_W  address currently driving memory
written  output  DEPTH  per-entry flag; 1 = entry written since last clear/reset
busy  output  1  clear sweep in progress

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All entries are zeroed.
  - memory=0, disp_addr=0, written=0, busy=0.
  - FSM goes to IDLE; scan counter, divider and store edge register are cleared.
  - Reset mid-sweep aborts the sweep immediately.
- Store edge: store_q is a register of store. A write fires when store=1, store_q=0, FSM=IDLE, and clear is not being accepted that cycle.
  - Holding store high writes exactly once.
  - A store edge while busy is dropped, not queued.
- Write: at the firing edge, mem[addr] <= data and written[addr] <= 1. If addr >= DEPTH, the write is ignored and written is unchanged.
- Read path: memory <= (disp_addr_next < DEPTH) ? mem[disp_addr_next] : 0 every cycle, giving one cycle of latency from display address to memory.
  - A word written at edge N appears on memory at edge N+1 if its address is displayed.
  - There is no write-through bypass.
- Display address:
  - scan_en=0: disp_addr <= addr; the scan counter and divider are held at 0.
  - scan_en=1: the divider counts 0..SCAN_DIV-1. On terminal count the scan index advances, wrapping DEPTH-1 -> 0. disp_addr <= scan index.
  - On a 0->1 transition of scan_en, scanning starts from entry 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear=1. Clear has priority over a coincident store edge, which is dropped. The sweep index is set to 0 and busy goes to 1 on the same edge.
  - In CLEAR, one entry per cycle: mem[idx] <= 0, written[idx] <= 0, idx++.
  - After entry DEPTH-1 is cleared, return to IDLE with busy=0. busy is high for exactly DEPTH cycles.
  - clear asserted while in CLEAR is ignored. Clear held high after the sweep starts a new sweep on the first IDLE cycle.
- The display keeps running during a sweep. memory shows zeros as entries are cleared, with the same one-cycle latency.

Test Plan:
- Reset with store=1, data=8'hFF -> memory=0, written=4'b0000, busy=0; no write until store drops and rises again.
- addr=2, data=8'hA5, store rises and is held for 5 cycles -> mem[2]=8'hA5 written once, written=4'b0100, memory=8'hA5 one cycle after the write edge.
- Write 8'h11, 8'h22, 8'h33, 8'h44 to addr 0..3, then scan_en=1 with SCAN_DIV=4 -> memory sequence 11,22,33,44,11,..., each value held 4 cycles; disp_addr wraps 3->0.
- After the fills above, clear pulse with a coincident store edge to addr 1 -> busy high exactly 4 cycles, store dropped, all entries 0, written=0, then IDLE.
- DEPTH=5 (ADDR_W=3): write to addr=6 -> ignored, memory reads 0 at addr 6; rst_n=0 two cycles into a clear sweep -> busy=0 next edge and all outputs at reset values.

Source files
------------

// File: rtl/mem_bank_seq_if.sv
// Switch/button side and display side signals of the memory bank.
// The board-facing driver uses master; the bank itself uses slave.
interface mem_bank_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic [WIDTH-1:0]  data;
  logic              store;
  logic [ADDR_W-1:0] addr;
  logic              clear;
  logic              scan_en;
  logic [WIDTH-1:0]  memory;
  logic [ADDR_W-1:0] disp_addr;
  logic [DEPTH-1:0]  written;
  logic              busy;

  modport master (
    output data, store, addr, clear, scan_en,
    input  memory, disp_addr, written, busy
  );

  modport slave (
    input  data, store, addr, clear, scan_en,
    output memory, disp_addr, written, busy
  );
endinterface

// File: rtl/mem_bank_seq.sv
// DEPTH x WIDTH register bank: edge-triggered switch writes, registered
// display (fixed address or auto-scan) and a one-entry-per-cycle clear sweep.
module mem_bank_seq #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int SCAN_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_bank_seq_if.slave bus
);

  localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_idx, clr_idx_next;
  logic              clear_go;
  logic              clr_active;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  written_q;
  logic              store_q;
  logic              store_fire;

  logic [DIV_W-1:0]  div_cnt;
  logic [ADDR_W-1:0] scan_idx;
  logic [ADDR_W-1:0] disp_next;
  logic [ADDR_W-1:0] disp_addr_q;
  logic [WIDTH-1:0]  rd_word;
  logic [WIDTH-1:0]  memory_q;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    clear_go     = 1'b0;
    clr_active   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          clear_go     = 1'b1;
          state_next   = CLEAR;
          clr_idx_next = '0;
        end
      end
      CLEAR: begin
        clr_active = 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_next   = IDLE;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        clr_idx_next = '0;
      end
    endcase
  end

  // A clear accepted this cycle wins over a simultaneous store edge.
  assign store_fire = bus.store && !store_q && (state == IDLE) && !clear_go;

  assign disp_next = bus.scan_en ? scan_idx : bus.addr;

  // Out-of-range display addresses fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_next == ADDR_W'(i)) rd_word = mem[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and simulation matches hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      clr_idx     <= '0;
      store_q     <= 1'b0;
      div_cnt     <= '0;
      scan_idx    <= '0;
      disp_addr_q <= '0;
      memory_q    <= '0;
      written_q   <= '0;
    end else begin
      state       <= state_next;
      clr_idx     <= clr_idx_next;
      store_q     <= bus.store;
      disp_addr_q <= disp_next;
      memory_q    <= rd_word;

      if (!bus.scan_en) begin
        div_cnt  <= '0;
        scan_idx <= '0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (clr_active && (clr_idx == ADDR_W'(i))) begin
          written_q[i] <= 1'b0;
        end else if (store_fire && (bus.addr == ADDR_W'(i))) begin
          written_q[i] <= 1'b1;
        end
      end
    end
  end

  // NOTE: the storage array is reset because the bank must read back as all
  // zeros after reset; it is a small flop array, not an inferred RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_active && (clr_idx == ADDR_W'(i))) begin
          mem[i] <= '0;
        end else if (store_fire && (bus.addr == ADDR_W'(i))) begin
          mem[i] <= bus.data;
        end
      end
    end
  end

  assign bus.memory    = memory_q;
  assign bus.disp_addr = disp_addr_q;
  assign bus.written   = written_q;
  assign bus.busy      = (state == CLEAR);

endmodule

// File: tb/tb_mem_bank_seq.sv
// Self-checking bench for mem_bank_seq: a DEPTH=4 instance checked by vector
// tables, directed sequences and a random run against a reference model, plus
// a DEPTH=5 instance for out-of-range addresses and reset mid-sweep.
module tb_mem_bank_seq;

  localparam int D4 = 4;
  localparam int S4 = 4;

  logic clk = 1'b0;
  logic rst_n4 = 1'b0;
  logic rst_n5 = 1'b0;
  always #5 clk = ~clk;

  mem_bank_seq_if #(.WIDTH(8), .DEPTH(4)) b4 ();
  mem_bank_seq_if #(.WIDTH(8), .DEPTH(5)) b5 ();

  mem_bank_seq #(.WIDTH(8), .DEPTH(4), .SCAN_DIV(S4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .bus(b4)
  );
  mem_bank_seq #(.WIDTH(8), .DEPTH(5), .SCAN_DIV(2)) dut5 (
    .clk(clk), .rst_n(rst_n5), .bus(b5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the DEPTH=4 bank: sweeps as a countdown of remaining
  // entries, scan position as elapsed scan cycles divided down.
  logic [7:0] m_mem [D4];
  logic [3:0] m_written;
  bit         m_prev_store;
  int         m_clear_left;
  int         m_scan_cycles;
  logic [7:0] m_memory;
  logic [1:0] m_disp;

  task automatic model_reset();
    for (int i = 0; i < D4; i++) m_mem[i] = 8'h00;
    m_written     = '0;
    m_prev_store  = 1'b0;
    m_clear_left  = 0;
    m_scan_cycles = 0;
    m_memory      = 8'h00;
    m_disp        = 2'd0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic st, input logic [1:0] a,
                            input logic cl, input logic sc);
    int dn;
    int idx;
    dn = sc ? (m_scan_cycles / S4) % D4 : int'(a);
    m_memory = m_mem[dn];
    m_disp   = 2'(dn);
    m_scan_cycles = sc ? m_scan_cycles + 1 : 0;
    if (m_clear_left > 0) begin
      idx = D4 - m_clear_left;
      m_mem[idx] = 8'h00;
      m_written[idx] = 1'b0;
      m_clear_left--;
    end else if (cl) begin
      m_clear_left = D4;
    end else if (st && !m_prev_store) begin
      m_mem[a] = d;
      m_written[a] = 1'b1;
    end
    m_prev_store = st;
  endtask

  task automatic tick4(input logic [7:0] d, input logic st, input logic [1:0] a,
                       input logic cl, input logic sc);
    b4.data = d; b4.store = st; b4.addr = a; b4.clear = cl; b4.scan_en = sc;
    @(posedge clk);
    if (!rst_n4) model_reset();
    else model_step(d, st, a, cl, sc);
    #1;
  endtask

  task automatic tick5(input logic [7:0] d, input logic st, input logic [2:0] a,
                       input logic cl, input logic sc);
    b5.data = d; b5.store = st; b5.addr = a; b5.clear = cl; b5.scan_en = sc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string name, input logic [7:0] em, input logic [3:0] ew,
                      input logic eb);
    check({name, ".memory"},  b4.memory,  em);
    check({name, ".written"}, b4.written, ew);
    check({name, ".busy"},    b4.busy,    eb);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       store;
    logic [1:0] addr;
    logic [7:0] exp_mem;
    logic [3:0] exp_wr;
  } vec_t;

  vec_t vecs[14];
  logic [7:0] fill [4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r_data;
    logic       r_store, r_clear, r_scan;
    logic [1:0] r_addr;
    int         sidx;

    vecs[0]  = '{8'hA5, 1'b1, 2'd2, 8'h00, 4'b0100};
    vecs[1]  = '{8'h5A, 1'b1, 2'd2, 8'hA5, 4'b0100};
    vecs[2]  = '{8'h5A, 1'b1, 2'd2, 8'hA5, 4'b0100};
    vecs[3]  = '{8'h5A, 1'b1, 2'd2, 8'hA5, 4'b0100};
    vecs[4]  = '{8'h5A, 1'b1, 2'd2, 8'hA5, 4'b0100};
    vecs[5]  = '{8'h5A, 1'b0, 2'd2, 8'hA5, 4'b0100};
    vecs[6]  = '{8'h11, 1'b1, 2'd0, 8'h00, 4'b0101};
    vecs[7]  = '{8'h00, 1'b0, 2'd0, 8'h11, 4'b0101};
    vecs[8]  = '{8'h22, 1'b1, 2'd1, 8'h00, 4'b0111};
    vecs[9]  = '{8'h00, 1'b0, 2'd1, 8'h22, 4'b0111};
    vecs[10] = '{8'h33, 1'b1, 2'd2, 8'hA5, 4'b0111};
    vecs[11] = '{8'h00, 1'b0, 2'd2, 8'h33, 4'b0111};
    vecs[12] = '{8'h44, 1'b1, 2'd3, 8'h00, 4'b1111};
    vecs[13] = '{8'h00, 1'b0, 2'd3, 8'h44, 4'b1111};
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};

    b5.data = '0; b5.store = 1'b0; b5.addr = '0; b5.clear = 1'b0; b5.scan_en = 1'b0;
    model_reset();

    // Reset with store high and data FF: nothing may be written.
    for (int i = 0; i < 3; i++) tick4(8'hFF, 1'b1, 2'd2, 1'b0, 1'b0);
    chk4("reset", 8'h00, 4'b0000, 1'b0);
    check("reset.disp_addr", b4.disp_addr, 2'd0);
    tick4(8'hFF, 1'b0, 2'd2, 1'b0, 1'b0);
    rst_n4 = 1'b1;
    tick4(8'hFF, 1'b0, 2'd2, 1'b0, 1'b0);
    chk4("post_reset", 8'h00, 4'b0000, 1'b0);
    check("post_reset.disp_addr", b4.disp_addr, 2'd2);

    // Held store writes once; then fill 11,22,33,44.
    for (int i = 0; i < 14; i++) begin
      tick4(vecs[i].data, vecs[i].store, vecs[i].addr, 1'b0, 1'b0);
      chk4($sformatf("vec%0d", i), vecs[i].exp_mem, vecs[i].exp_wr, 1'b0);
      check($sformatf("vec%0d.disp_addr", i), b4.disp_addr, vecs[i].addr);
    end

    // Scan: each entry held S4 cycles, wrapping 3 -> 0.
    for (int k = 0; k < 20; k++) begin
      tick4(8'h00, 1'b0, 2'd1, 1'b0, 1'b1);
      check($sformatf("scan%0d.disp_addr", k), b4.disp_addr, (k / S4) % D4);
      check($sformatf("scan%0d.memory", k), b4.memory, fill[(k / S4) % D4]);
    end
    tick4(8'h00, 1'b0, 2'd1, 1'b0, 1'b0);
    check("scan_off.disp_addr", b4.disp_addr, 2'd1);

    // Clear with coincident store edge; another store edge mid-sweep.
    tick4(8'h99, 1'b1, 2'd1, 1'b1, 1'b0);
    chk4("clr0", 8'h22, 4'b1111, 1'b1);
    tick4(8'h77, 1'b0, 2'd1, 1'b0, 1'b0);
    chk4("clr1", 8'h22, 4'b1110, 1'b1);
    tick4(8'h77, 1'b1, 2'd1, 1'b0, 1'b0);
    chk4("clr2", 8'h22, 4'b1100, 1'b1);
    tick4(8'h77, 1'b1, 2'd1, 1'b0, 1'b0);
    chk4("clr3", 8'h00, 4'b1000, 1'b1);
    tick4(8'h77, 1'b1, 2'd1, 1'b0, 1'b0);
    chk4("clr4", 8'h00, 4'b0000, 1'b0);
    tick4(8'h77, 1'b1, 2'd1, 1'b0, 1'b0);
    chk4("clr5", 8'h00, 4'b0000, 1'b0);
    for (int i = 0; i < D4; i++) begin
      tick4(8'h00, 1'b0, 2'(i), 1'b0, 1'b0);
      tick4(8'h00, 1'b0, 2'(i), 1'b0, 1'b0);
      chk4($sformatf("cleared%0d", i), 8'h00, 4'b0000, 1'b0);
    end

    // Random run against the reference model.
    rst_n4 = 1'b0;
    tick4(8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    rst_n4 = 1'b1;
    r_scan = 1'b0;
    for (int t = 0; t < 600; t++) begin
      r_data  = 8'($urandom);
      r_store = 1'($urandom_range(0, 1));
      r_addr  = 2'($urandom_range(0, 3));
      r_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 24) == 0) r_scan = !r_scan;
      tick4(r_data, r_store, r_addr, r_clear, r_scan);
      check($sformatf("rand%0d.memory", t),    b4.memory,    m_memory);
      check($sformatf("rand%0d.disp_addr", t), b4.disp_addr, m_disp);
      check($sformatf("rand%0d.written", t),   b4.written,   m_written);
      check($sformatf("rand%0d.busy", t),      b4.busy,      (m_clear_left > 0));
    end

    // DEPTH=5 instance.
    tick5(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tick5(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n5 = 1'b1;
    tick5(8'h5C, 1'b1, 3'd6, 1'b0, 1'b0);
    tick5(8'h5C, 1'b0, 3'd6, 1'b0, 1'b0);
    check("d5_oob.memory", b5.memory, 8'h00);
    check("d5_oob.disp_addr", b5.disp_addr, 3'd6);
    check("d5_oob.written", b5.written, 5'b00000);
    tick5(8'hC3, 1'b1, 3'd4, 1'b0, 1'b0);
    check("d5_wr4.written", b5.written, 5'b10000);
    tick5(8'hC3, 1'b0, 3'd4, 1'b0, 1'b0);
    check("d5_rd4.memory", b5.memory, 8'hC3);
    tick5(8'h00, 1'b0, 3'd7, 1'b0, 1'b0);
    check("d5_rd7.memory", b5.memory, 8'h00);
    for (int k = 0; k < 12; k++) begin
      tick5(8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
      sidx = (k / 2) % 5;
      check($sformatf("d5_scan%0d.disp_addr", k), b5.disp_addr, sidx);
      check($sformatf("d5_scan%0d.memory", k), b5.memory, (sidx == 4) ? 8'hC3 : 8'h00);
    end
    tick5(8'h00, 1'b0, 3'd4, 1'b0, 1'b0);
    tick5(8'h00, 1'b0, 3'd4, 1'b1, 1'b0);
    check("d5_sweep0.busy", b5.busy, 1'b1);
    tick5(8'h00, 1'b0, 3'd4, 1'b0, 1'b0);
    tick5(8'h00, 1'b0, 3'd4, 1'b0, 1'b0);
    check("d5_sweep2.busy", b5.busy, 1'b1);
    rst_n5 = 1'b0;
    tick5(8'h00, 1'b0, 3'd4, 1'b0, 1'b0);
    check("d5_abort.busy", b5.busy, 1'b0);
    check("d5_abort.memory", b5.memory, 8'h00);
    check("d5_abort.disp_addr", b5.disp_addr, 3'd0);
    check("d5_abort.written", b5.written, 5'b00000);
    rst_n5 = 1'b1;
    tick5(8'h00, 1'b0, 3'd4, 1'b0, 1'b0);
    check("d5_after.memory", b5.memory, 8'h00);
    check("d5_after.busy", b5.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
